// File: rtl/nibble_rev_tx_if.sv
// Word handshake plus nibble strobe bundle for nibble_rev_tx.
// The slave side is the transmitter; the master side is whatever feeds it and watches the strobes.
interface nibble_rev_tx_if;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_data;
  logic        o_en;
  logic [3:0]  o_a;
  logic        o_busy;
  logic        o_done;

  modport master (
    output i_valid,
    output i_data,
    input  o_ready,
    input  o_en,
    input  o_a,
    input  o_busy,
    input  o_done
  );

  modport slave (
    input  i_valid,
    input  i_data,
    output o_ready,
    output o_en,
    output o_a,
    output o_busy,
    output o_done
  );
endinterface

// File: rtl/nibble_rev_tx.sv
// Serialises an accepted 16-bit word as four bit-reversed nibble strobes,
// with an optional idle gap between strobes and a done pulse on the last one.
module nibble_rev_tx #(
  parameter int unsigned GAP       = 0,
  parameter bit          LSN_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  nibble_rev_tx_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [2:0] GAP_L = 3'(GAP);

  state_t      state_q;
  logic [1:0]  idx_q;
  logic [2:0]  gap_q;
  logic [15:0] data_q;
  logic        en_q;
  logic [3:0]  a_q;
  logic        done_q;
  logic        busy_q;
  logic [1:0]  idx_d;

  // Pick nibble k in transmit order and mirror its bits.
  function automatic logic [3:0] nib_rev(input logic [15:0] w, input logic [1:0] k);
    logic [3:0] n;
    if (LSN_FIRST) begin
      n = w[{k, 2'b00} +: 4];
    end else begin
      n = w[(4'd12 - {k, 2'b00}) +: 4];
    end
    return {n[0], n[1], n[2], n[3]};
  endfunction

  assign idx_d = idx_q + 2'd1;

  // Sequencer: state, index, gap count, captured word and all strobe outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      gap_q   <= 3'd0;
      data_q  <= 16'd0;
      en_q    <= 1'b0;
      a_q     <= 4'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          en_q   <= 1'b0;
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (bus.i_valid) begin
            data_q  <= bus.i_data;
            idx_q   <= 2'd0;
            state_q <= SEND;
            en_q    <= 1'b1;
            a_q     <= nib_rev(bus.i_data, 2'd0);
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        SEND: begin
          if (idx_q == 2'd3) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (GAP_L == 3'd0) begin
            state_q <= SEND;
            idx_q   <= idx_d;
            en_q    <= 1'b1;
            a_q     <= nib_rev(data_q, idx_d);
            done_q  <= (idx_d == 2'd3);
          end else begin
            // Counter preloaded with GAP-1 so WAIT spans exactly GAP cycles.
            state_q <= WAIT;
            gap_q   <= GAP_L - 3'd1;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        WAIT: begin
          if (gap_q == 3'd0) begin
            state_q <= SEND;
            idx_q   <= idx_d;
            en_q    <= 1'b1;
            a_q     <= nib_rev(data_q, idx_d);
            done_q  <= (idx_d == 2'd3);
          end else begin
            gap_q   <= gap_q - 3'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= 2'd0;
          gap_q   <= 3'd0;
          en_q    <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ready = (state_q == IDLE);
  assign bus.o_en    = en_q;
  assign bus.o_a     = a_q;
  assign bus.o_done  = done_q;
  assign bus.o_busy  = busy_q;

endmodule

// File: tb/tb_nibble_rev_tx.sv
// Directed and receiver-model checks of nibble_rev_tx; instances 0..7 use GAP=index
// with LSN_FIRST=1, instance 8 uses GAP=0 with LSN_FIRST=0.
module tb_nibble_rev_tx;

  logic        clk_s = 1'b0;
  logic        rst_s;
  logic [8:0]  vld_s;
  logic [15:0] dat_s [0:8];
  logic [8:0]  rdy_s, en_s, busy_s, done_s;
  logic [3:0]  a_s [0:8];
  int          checks_s = 0;
  int          fails_s  = 0;

  always #5 clk_s = ~clk_s;

  generate
    for (genvar g = 0; g < 9; g++) begin : g_dut
      nibble_rev_tx_if bus ();
      assign bus.i_valid = vld_s[g];
      assign bus.i_data  = dat_s[g];
      assign rdy_s[g]    = bus.o_ready;
      assign en_s[g]     = bus.o_en;
      assign a_s[g]      = bus.o_a;
      assign busy_s[g]   = bus.o_busy;
      assign done_s[g]   = bus.o_done;
      nibble_rev_tx #(
        .GAP       ((g == 8) ? 0 : g),
        .LSN_FIRST ((g == 8) ? 1'b0 : 1'b1)
      ) u_dut (
        .i_clk (clk_s),
        .i_rst (rst_s),
        .bus   (bus)
      );
    end
  endgenerate

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks_s++;
    if (obs !== exp_v) begin
      fails_s++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_state(input int k, input string tag, input logic en, input logic [3:0] a,
                             input logic done, input logic busy, input logic rdy);
    check_eq({tag, "_en"},   en_s[k],   en);
    check_eq({tag, "_a"},    a_s[k],    a);
    check_eq({tag, "_done"}, done_s[k], done);
    check_eq({tag, "_busy"}, busy_s[k], busy);
    check_eq({tag, "_rdy"},  rdy_s[k],  rdy);
  endtask

  // Receiver side: latched nibble un-reversed.
  function automatic logic [3:0] rev4(input logic [3:0] n);
    return {n[0], n[1], n[2], n[3]};
  endfunction

  // exp_a holds the four expected o_a values in strobe order, first one in [3:0].
  task automatic run_word(input int k, input logic [15:0] w, input logic [15:0] exp_a,
                          input int gap, input string tag);
    logic strobe;
    int   j;
    @(negedge clk_s);
    vld_s[k] = 1'b1;
    dat_s[k] = w;
    @(posedge clk_s);
    @(negedge clk_s);
    vld_s[k] = 1'b0;
    dat_s[k] = ~w;
    for (int c = 1; c <= 4 + 3 * gap; c++) begin
      if (c > 1) @(negedge clk_s);
      strobe = (((c - 1) % (gap + 1)) == 0);
      j      = (c - 1) / (gap + 1);
      check_state(k, tag, strobe, exp_a[4*j +: 4], strobe && (j == 3), 1'b1, 1'b0);
    end
    @(negedge clk_s);
    check_state(k, {tag, "_end"}, 1'b0, exp_a[15:12], 1'b0, 1'b0, 1'b1);
  endtask

  task automatic run_rx(input int k, input logic [15:0] w);
    logic [15:0] rx;
    int          cnt;
    int          pos;
    logic        seen_done;
    @(negedge clk_s);
    vld_s[k] = 1'b1;
    dat_s[k] = w;
    @(posedge clk_s);
    @(negedge clk_s);
    vld_s[k]  = 1'b0;
    dat_s[k]  = ~w;
    rx        = 16'd0;
    cnt       = 0;
    seen_done = 1'b0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      if (c > 0) @(negedge clk_s);
      if (en_s[k]) begin
        pos = (k == 8) ? (12 - 4 * cnt) : (4 * cnt);
        if (cnt < 4) rx[pos +: 4] = rev4(a_s[k]);
        cnt++;
        if (done_s[k]) seen_done = 1'b1;
      end
    end
    check_eq("r035_word", rx, w);
    check_eq("r035_cnt", cnt, 32'd4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  exp033a [0:3];
    logic [3:0]  exp033b [0:3];
    int          k;
    logic [15:0] w;
    exp033a = '{4'hB, 4'h3, 4'hD, 4'h5};
    exp033b = '{4'h7, 4'h8, 4'hF, 4'h0};
    rst_s = 1'b1;
    vld_s = 9'd0;
    for (int i = 0; i < 9; i++) dat_s[i] = 16'd0;
    repeat (2) @(posedge clk_s);
    @(negedge clk_s);
    rst_s = 1'b0;
    for (int i = 0; i < 9; i++) check_state(i, "reset", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);

    run_word(0, 16'h1234, 16'h84C2, 0, "r030");
    run_word(8, 16'h1234, 16'h2C48, 0, "r031");
    run_word(2, 16'hF0A5, 16'hF05A, 2, "r032");

    // Valid held high with data churning; second word taken when ready returns.
    @(negedge clk_s);
    vld_s[0] = 1'b1;
    dat_s[0] = 16'hABCD;
    @(posedge clk_s);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_s);
      dat_s[0] = {4{4'(c + 1)}};
      check_state(0, "r033a", 1'b1, exp033a[c], (c == 3), 1'b1, 1'b0);
    end
    @(negedge clk_s);
    check_eq("r033_rdy", rdy_s[0], 1'b1);
    dat_s[0] = 16'h0F1E;
    @(posedge clk_s);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_s);
      vld_s[0] = 1'b0;
      dat_s[0] = 16'hFFFF;
      check_state(0, "r033b", 1'b1, exp033b[c], (c == 3), 1'b1, 1'b0);
    end
    @(negedge clk_s);
    check_state(0, "r033_end", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);

    // Reset during the second strobe aborts the word.
    @(negedge clk_s);
    vld_s[0] = 1'b1;
    dat_s[0] = 16'h1234;
    @(posedge clk_s);
    @(negedge clk_s);
    vld_s[0] = 1'b0;
    check_state(0, "r034_s1", 1'b1, 4'h2, 1'b0, 1'b1, 1'b0);
    @(negedge clk_s);
    check_state(0, "r034_s2", 1'b1, 4'hC, 1'b0, 1'b1, 1'b0);
    rst_s = 1'b1;
    @(negedge clk_s);
    rst_s = 1'b0;
    check_state(0, "r034_rst", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    repeat (4) begin
      @(negedge clk_s);
      check_eq("r034_quiet_en", en_s[0], 1'b0);
      check_eq("r034_quiet_done", done_s[0], 1'b0);
    end
    run_word(0, 16'h1234, 16'h84C2, 0, "r034_new");

    // Reset wins over a simultaneous acceptance.
    @(negedge clk_s);
    vld_s[0] = 1'b1;
    dat_s[0] = 16'h5A5A;
    rst_s    = 1'b1;
    @(negedge clk_s);
    vld_s[0] = 1'b0;
    rst_s    = 1'b0;
    check_state(0, "r029", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk_s);
    check_state(0, "r029_next", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      k = $urandom_range(0, 8);
      w = 16'($urandom);
      run_rx(k, w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_s, fails_s);
    $finish;
  end

endmodule
